data_write_buffer: RTL and testbench

Posted-store buffer between the CPU memory-access stage and the word-addressed data memory. Stores are queued in a small FIFO and retired one per cycle whenever the memory port is free. Loads take priority on the port, and loads that hit a queued store are forwarded from the buffer. This decouples CPU stores from cycles where another master or an in-flight load owns the data memory.

---
 rtl/data_write_buffer.sv | 143 ++++++++++++++
 tb/tb_data_write_buffer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/data_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_write_buffer
// Purpose  : Posted-store buffer between the CPU memory-access stage and a
//            word-addressed data memory. Stores are queued in a circular FIFO
//            and retired one per cycle when the memory port is free. Loads own
//            the port; loads that hit a queued store are forwarded from the
//            youngest matching entry.
// Options  : WBUF_COALESCE_EN - when defined, a store to the same word as the
//            youngest entry overwrites that entry in place.
// Ports    : clk, reset          - clock, synchronous active-high reset
//            cpu_rd/cpu_wr       - CPU load / store request
//            cpu_addr/cpu_wdata  - byte address (word aligned) / store data
//            cpu_rdata           - load data (combinational)
//            cpu_stall           - CPU must hold its request and retry
//            drain               - empty the buffer before proceeding
//            mem_ready           - memory port free for a buffered write
//            mem_rd/mem_wr       - memory read / write enables
//            mem_addr/mem_wdata  - memory address / write data
//            mem_rdata           - memory read data (combinational)
//            count/empty         - occupancy / occupancy == 0
// Revision : 1.0 - initial release
// ============================================================================
module data_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_rd,
  input  logic          cpu_wr,
  input  logic [31:0]   cpu_addr,
  input  logic [31:0]   cpu_wdata,
  output logic [31:0]   cpu_rdata,
  output logic          cpu_stall,
  input  logic          drain,
  input  logic          mem_ready,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic [CW-1:0] count,
  output logic          empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Entry storage; contents are only meaningful between head and tail,
  // so the arrays themselves carry no reset.
  logic [29:0]   r_addr [DEPTH];
  logic [31:0]   r_data [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  logic          w_hit;
  logic [31:0]   w_fwd;
  logic          w_miss;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_stall;
  logic          w_coal_ok;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_hit = 1'b0;
    w_fwd = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) &&
          (r_addr[r_head + AW'(k)] == cpu_addr[31:2])) begin
        w_hit = 1'b1;
        w_fwd = r_data[r_head + AW'(k)];
      end
    end
  end

  // A load miss owns the memory port, so nothing retires that cycle.
  assign w_miss = cpu_rd & ~w_hit;
  assign w_pop  = ~reset & ~w_empty & mem_ready & ~w_miss;

`ifdef WBUF_COALESCE_EN
  logic [AW-1:0] w_young;
  logic          w_coal;
  assign w_young = r_tail - AW'(1);
  // Merging into the head while it is leaving would lose the new data,
  // so that case allocates a fresh entry instead.
  assign w_coal_ok = cpu_wr & ~w_empty &
                     (r_addr[w_young] == cpu_addr[31:2]) &
                     ~(w_pop & (r_count == CW'(1)));
  assign w_coal    = ~reset & w_coal_ok & ~w_stall;
`else
  assign w_coal_ok = 1'b0;
`endif

  // A store held off by a drain is not accepted; the CPU retries it.
  assign w_stall = ~reset & ((drain & ~w_empty) |
                             (cpu_wr & w_full & ~w_pop & ~w_coal_ok));
  assign w_push  = ~reset & cpu_wr & ~w_stall & ~w_coal_ok & (~w_full | w_pop);

  assign cpu_stall = w_stall;
  assign mem_rd    = ~reset & w_miss;
  assign mem_wr    = w_pop;
  assign mem_addr  = w_miss ? cpu_addr : {r_addr[r_head], 2'b00};
  assign mem_wdata = r_data[r_head];
  assign cpu_rdata = (reset | ~cpu_rd) ? '0 : (w_hit ? w_fwd : mem_rdata);
  assign count     = r_count;
  assign empty     = w_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop)  r_head <= r_head + AW'(1);
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_push & ~w_pop)
        r_count <= r_count + CW'(1);
      else if (w_pop & ~w_push)
        r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= cpu_addr[31:2];
      r_data[r_tail] <= cpu_wdata;
    end
`ifdef WBUF_COALESCE_EN
    else if (w_coal) begin
      r_data[w_young] <= cpu_wdata;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_data_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_write_buffer
// Purpose  : Self-checking bench for data_write_buffer: directed vector table
//            followed by random stimulus against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_write_buffer;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
`ifdef WBUF_COALESCE_EN
  localparam int CO = 1;
`else
  localparam int CO = 0;
`endif

  logic          clk = 1'b0;
  logic          reset, cpu_rd, cpu_wr, drain, mem_ready;
  logic [31:0]   cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall, mem_rd, mem_wr, empty;
  logic [31:0]   mem_addr, mem_wdata, mem_rdata;
  logic [CW-1:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Memory returns a value derived from the address it is given.
  assign mem_rdata = mem_addr ^ 32'h5A5A_0000;

  data_write_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .reset(reset), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .drain(drain), .mem_ready(mem_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .count(count), .empty(empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of pending stores ----------------
  typedef struct { logic [29:0] wa; logic [31:0] d; } ent_t;
  ent_t q[$];
  logic m_pop, m_push, m_coal;

  task automatic model_check();
    logic hit, miss, stall, e_rd;
    logic [31:0] fwd, e_rdata;
    int sz;
    sz  = q.size();
    hit = 1'b0;
    fwd = '0;
    foreach (q[i]) if (q[i].wa == cpu_addr[31:2]) begin hit = 1'b1; fwd = q[i].d; end
    miss   = cpu_rd && !hit;
    m_pop  = !reset && sz > 0 && mem_ready && !miss;
    m_coal = 1'b0;
    if (CO != 0 && !reset && cpu_wr && sz > 0)
      m_coal = (q[sz-1].wa == cpu_addr[31:2]) && !(m_pop && sz == 1);
    stall  = !reset && ((drain && sz > 0) || (cpu_wr && sz == DEPTH && !m_pop && !m_coal));
    if (stall) m_coal = 1'b0;
    m_push = !reset && cpu_wr && !stall && !m_coal && (sz < DEPTH || m_pop);
    e_rd    = !reset && miss;
    e_rdata = (reset || !cpu_rd) ? 32'h0 : (hit ? fwd : (cpu_addr ^ 32'h5A5A_0000));
    chk("model mem_rd",    mem_rd,    e_rd);
    chk("model mem_wr",    mem_wr,    m_pop);
    chk("model cpu_stall", cpu_stall, stall);
    chk("model cpu_rdata", cpu_rdata, e_rdata);
    chk("model count",     count,     sz);
    chk("model empty",     empty,     sz == 0);
    if (e_rd) chk("model mem_addr(rd)", mem_addr, cpu_addr);
    if (m_pop) begin
      chk("model mem_addr(wr)", mem_addr,  {q[0].wa, 2'b00});
      chk("model mem_wdata",    mem_wdata, q[0].d);
    end
  endtask

  task automatic model_update();
    if (reset) q.delete();
    else begin
      if (m_coal) q[q.size()-1].d = cpu_wdata;
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back('{wa: cpu_addr[31:2], d: cpu_wdata});
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rst, rd, wr, dr, rdy;
    logic [31:0] a, d;
    logic erd, ewr;
    logic [31:0] ea, ed, er;
    logic est;
    int ec;
  } vec_t;
  vec_t tv[$];

  function automatic vec_t mk(input logic rst, rd, wr, dr, rdy,
                              input logic [31:0] a, d,
                              input logic erd, ewr,
                              input logic [31:0] ea, ed, er,
                              input logic est, input int ec);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.dr = dr; v.rdy = rdy; v.a = a; v.d = d;
    v.erd = erd; v.ewr = ewr; v.ea = ea; v.ed = ed; v.er = er; v.est = est; v.ec = ec;
    return v;
  endfunction

  task automatic drive(input logic rst, rd, wr, dr, rdy, input logic [31:0] a, d);
    reset = rst; cpu_rd = rd; cpu_wr = wr; drain = dr; mem_ready = rdy;
    cpu_addr = a; cpu_wdata = d;
  endtask

  task automatic row_check(input int i);
    chk($sformatf("row%0d mem_rd", i),    mem_rd,    tv[i].erd);
    chk($sformatf("row%0d mem_wr", i),    mem_wr,    tv[i].ewr);
    chk($sformatf("row%0d cpu_stall", i), cpu_stall, tv[i].est);
    chk($sformatf("row%0d cpu_rdata", i), cpu_rdata, tv[i].er);
    chk($sformatf("row%0d count", i),     count,     tv[i].ec);
    if (tv[i].erd || tv[i].ewr) chk($sformatf("row%0d mem_addr", i), mem_addr, tv[i].ea);
    if (tv[i].ewr) chk($sformatf("row%0d mem_wdata", i), mem_wdata, tv[i].ed);
  endtask

  task automatic step_model();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int c2;
    c2 = (CO != 0) ? 1 : 2;
    //                rst rd wr dr rdy addr          wdata          erd ewr ea            ed            erdata        est cnt
    tv.push_back(mk(1, 0, 1, 0, 1, 32'h10,       32'h1,         0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 1, 32'h10,       32'hDEADBEEF,  0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 1, 32'h10,       32'hDEADBEEF, 0,            0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h0,        32'hA0,        0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h4,        32'hA1,        0, 0, 0,            0,            0,            0, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h8,        32'hA2,        0, 0, 0,            0,            0,            0, 2));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'hC,        32'hA3,        0, 0, 0,            0,            0,            0, 3));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h10,       32'hA4,        0, 0, 0,            0,            0,            1, 4));
    tv.push_back(mk(0, 0, 1, 0, 1, 32'h10,       32'hA4,        0, 1, 32'h0,        32'hA0,       0,            0, 4));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 1, 32'h4,        32'hA1,       0,            0, 4));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 1, 32'h8,        32'hA2,       0,            0, 3));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 1, 32'hC,        32'hA3,       0,            0, 2));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 1, 32'h10,       32'hA4,       0,            0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h20,       32'h11,        0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h20,       32'h22,        0, 0, 0,            0,            0,            0, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 32'h20,       32'h0,         0, 0, 0,            0,            32'h22,       0, c2));
    tv.push_back(mk(0, 1, 0, 0, 1, 32'h24,       32'h0,         1, 0, 32'h24,       0,            32'h5A5A0024, 0, c2));
    tv.push_back(mk(1, 0, 0, 0, 1, 32'h0,        32'h0,         0, 0, 0,            0,            0,            0, c2));
    tv.push_back(mk(0, 1, 0, 0, 1, 32'h20,       32'h0,         1, 0, 32'h20,       0,            32'h5A5A0020, 0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h30,       32'hB0,        0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h34,       32'hB1,        0, 0, 0,            0,            0,            0, 1));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h38,       32'hB2,        0, 0, 0,            0,            0,            0, 2));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h0,        32'h0,         0, 1, 32'h30,       32'hB0,       0,            1, 3));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h0,        32'h0,         0, 1, 32'h34,       32'hB1,       0,            1, 2));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h0,        32'h0,         0, 1, 32'h38,       32'hB2,       0,            1, 1));
    tv.push_back(mk(0, 0, 0, 1, 1, 32'h0,        32'h0,         0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h40,       32'hC1,        0, 0, 0,            0,            0,            0, 0));
    tv.push_back(mk(0, 0, 1, 0, 0, 32'h40,       32'hC2,        0, 0, 0,            0,            0,            0, 1));
    tv.push_back(mk(0, 1, 0, 0, 0, 32'h40,       32'h0,         0, 0, 0,            0,            32'hC2,       0, c2));
    tv.push_back(mk(1, 0, 0, 0, 0, 32'h0,        32'h0,         0, 0, 0,            0,            0,            0, c2));
    // Load and store together into an empty buffer: load misses, store lands,
    // and the new entry forwards only from the following cycle.
    tv.push_back(mk(0, 1, 1, 0, 1, 32'h60,       32'hE0,        1, 0, 32'h60,       0,            32'h5A5A0060, 0, 0));
    tv.push_back(mk(0, 1, 0, 0, 1, 32'h60,       32'h0,         0, 1, 32'h60,       32'hE0,       32'hE0,       0, 1));
    tv.push_back(mk(0, 0, 0, 0, 1, 32'h0,        32'h0,         0, 0, 0,            0,            0,            0, 0));

    drive(1, 0, 0, 0, 0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    q.delete();

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst, tv[i].rd, tv[i].wr, tv[i].dr, tv[i].rdy, tv[i].a, tv[i].d);
      @(negedge clk);
      model_check();
      row_check(i);
      @(posedge clk);
      model_update();
      #1;
    end

    for (int n = 0; n < 3000; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 1) != 0) a = a | 32'h8000_0000;
      drive($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 8,
            $urandom_range(0, 99) < 60, a, $urandom);
      step_model();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
